// File: rtl/keccak_rate_packer.sv
// Packs byte-enabled input beats into Keccak rate blocks and applies pad10*1 with the mode's domain suffix.
// Handshakes: a transfer happens on any rising edge where valid and ready are both high; a valid source holds its payload until that edge.
module keccak_rate_packer #(
  parameter int DWIDTH         = 256,
  parameter int MAX_RATE_BYTES = 168,
  parameter int MODE_SEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MODE_SEL_WIDTH-1:0]   mode_i,
  input  logic                        start_i,
  input  logic [DWIDTH-1:0]           in_data_i,
  input  logic [DWIDTH/8-1:0]         in_keep_i,
  input  logic                        in_valid_i,
  input  logic                        in_last_i,
  output logic                        in_ready_o,
  output logic [MAX_RATE_BYTES*8-1:0] blk_data_o,
  output logic                        blk_valid_o,
  input  logic                        blk_ready_i,
  output logic                        blk_last_o,
  output logic [7:0]                  blk_rate_o,
  output logic                        busy_o,
  output logic [1:0]                  dbg_state
);

  localparam int NB    = DWIDTH / 8;
  localparam int BLK_W = MAX_RATE_BYTES * 8;
  localparam int CW    = DWIDTH - 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    PAD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CW-1:0]    carry_q, carry_d;
  logic [7:0]       carry_cnt_q, carry_cnt_d;
  logic [7:0]       ptr_q, ptr_d;
  logic [7:0]       rate_q, rate_d;
  logic [7:0]       suffix_q, suffix_d;
  logic             last_q, last_d;
  logic             pad_pend_q, pad_pend_d;

  logic [7:0]       n_bytes;
  logic [DWIDTH-1:0] masked;
  logic [8:0]       sum;
  logic [8:0]       over;
  logic [7:0]       room;
  logic [7:0]       pad_pos;
  logic [BLK_W-1:0] ext;
  logic [BLK_W-1:0] shifted;
  logic [BLK_W-1:0] rate_mask;
  logic [BLK_W-1:0] suf_ext;
  logic [BLK_W-1:0] end_ext;
  logic [BLK_W-1:0] pad_vec;
  logic             beat_fire;

  // Beat preprocessing: byte count, masked data and its placement at ptr.
  always_comb begin
    n_bytes = '0;
    masked  = '0;
    for (int i = 0; i < NB; i++) begin
      n_bytes = n_bytes + 8'(in_keep_i[i]);
      masked[i*8 +: 8] = in_keep_i[i] ? in_data_i[i*8 +: 8] : 8'h00;
    end
    rate_mask = '0;
    for (int i = 0; i < MAX_RATE_BYTES; i++) begin
      rate_mask[i*8 +: 8] = (i < int'(rate_q)) ? 8'hFF : 8'h00;
    end
    ext             = '0;
    ext[DWIDTH-1:0] = masked;
    shifted         = ext << {ptr_q, 3'b000};
    sum             = {1'b0, ptr_q} + {1'b0, n_bytes};
    over            = sum - {1'b0, rate_q};
    room            = rate_q - ptr_q;
  end

  // Suffix lands at pad_pos, 0x80 at rate-1; OR-ing merges them when they coincide.
  always_comb begin
    pad_pos      = (state_q == PAD) ? ptr_q : sum[7:0];
    suf_ext      = '0;
    suf_ext[7:0] = suffix_q;
    end_ext      = '0;
    end_ext[7:0] = 8'h80;
    pad_vec      = (suf_ext << {pad_pos, 3'b000}) |
                   (end_ext << {rate_q - 8'd1, 3'b000});
  end

  assign in_ready_o = (state_q == FILL) && (carry_cnt_q == 8'd0);
  assign beat_fire  = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    ptr_d       = ptr_q;
    rate_d      = rate_q;
    suffix_d    = suffix_q;
    last_d      = last_q;
    pad_pend_d  = pad_pend_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          case (mode_i)
            MODE_SEL_WIDTH'(0): begin rate_d = 8'd136; suffix_d = 8'h06; end
            MODE_SEL_WIDTH'(1): begin rate_d = 8'd72;  suffix_d = 8'h06; end
            MODE_SEL_WIDTH'(2): begin rate_d = 8'd168; suffix_d = 8'h1F; end
            default:            begin rate_d = 8'd136; suffix_d = 8'h1F; end
          endcase
          blk_d       = '0;
          carry_d     = '0;
          carry_cnt_d = '0;
          ptr_d       = '0;
          last_d      = 1'b0;
          pad_pend_d  = 1'b0;
          state_d     = FILL;
        end
      end
      FILL: begin
        if (beat_fire) begin
          blk_d = blk_q | (shifted & rate_mask);
          if (sum < {1'b0, rate_q}) begin
            ptr_d = sum[7:0];
            if (in_last_i) begin
              blk_d   = blk_q | (shifted & rate_mask) | pad_vec;
              last_d  = 1'b1;
              state_d = EMIT;
            end
          end else begin
            pad_pend_d = in_last_i;
            state_d    = EMIT;
            if (sum != {1'b0, rate_q}) begin
              carry_d     = CW'(masked >> {room, 3'b000});
              carry_cnt_d = over[7:0];
            end
          end
        end
      end
      EMIT: begin
        if (blk_ready_i) begin
          blk_d          = '0;
          blk_d[CW-1:0]  = carry_q;
          ptr_d          = carry_cnt_q;
          carry_d        = '0;
          carry_cnt_d    = '0;
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else if (pad_pend_q) begin
            pad_pend_d = 1'b0;
            state_d    = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      PAD: begin
        blk_d   = blk_q | pad_vec;
        last_d  = 1'b1;
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      carry_q     <= '0;
      carry_cnt_q <= '0;
      ptr_q       <= '0;
      rate_q      <= '0;
      suffix_q    <= '0;
      last_q      <= 1'b0;
      pad_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
      ptr_q       <= ptr_d;
      rate_q      <= rate_d;
      suffix_q    <= suffix_d;
      last_q      <= last_d;
      pad_pend_q  <= pad_pend_d;
    end
  end

  assign blk_data_o  = blk_q;
  assign blk_valid_o = (state_q == EMIT);
  assign blk_last_o  = (state_q == EMIT) && last_q;
  assign blk_rate_o  = rate_q;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_keccak_rate_packer.sv
// Directed bench for keccak_rate_packer: a reference padding model fills an expected-block queue
// that a negedge monitor drains on every block handshake.
module tb_keccak_rate_packer;

  localparam int DWIDTH = 256;
  localparam int NB     = DWIDTH / 8;
  localparam int MAXR   = 168;
  localparam int BW     = MAXR * 8;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode_i;
  logic              start_i;
  logic [DWIDTH-1:0] in_data_i;
  logic [NB-1:0]     in_keep_i;
  logic              in_valid_i;
  logic              in_last_i;
  logic              in_ready_o;
  logic [BW-1:0]     blk_data_o;
  logic              blk_valid_o;
  logic              blk_ready_i;
  logic              blk_last_o;
  logic [7:0]        blk_rate_o;
  logic              busy_o;
  logic [1:0]        dbg_state;

  keccak_rate_packer #(.DWIDTH(DWIDTH), .MAX_RATE_BYTES(MAXR), .MODE_SEL_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .start_i(start_i),
    .in_data_i(in_data_i), .in_keep_i(in_keep_i), .in_valid_i(in_valid_i),
    .in_last_i(in_last_i), .in_ready_o(in_ready_o), .blk_data_o(blk_data_o),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_last_o(blk_last_o),
    .blk_rate_o(blk_rate_o), .busy_o(busy_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            blk_seen = 0;
  logic [BW-1:0] exp_q[$];
  logic [8:0]    exp_meta_q[$];
  logic [7:0]    seed;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_block(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = MAXR - 1; i >= 0; i--) begin
      if (act[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: byte %0d got 0x%0h, expected 0x%0h", name, bad,
               act[bad*8 +: 8], exp[bad*8 +: 8]);
    end
  endtask

  function automatic logic [7:0] pat(input int idx);
    return 8'(idx * 13 + int'(seed));
  endfunction

  // Reference pad10*1 model: whole message laid out in rate-sized blocks.
  task automatic push_msg(input int mode, input int len);
    int            r;
    int            nblk;
    int            idx;
    logic [7:0]    suf;
    logic [BW-1:0] blk;
    logic          lst;
    case (mode)
      0:       begin r = 136; suf = 8'h06; end
      1:       begin r = 72;  suf = 8'h06; end
      2:       begin r = 168; suf = 8'h1F; end
      default: begin r = 136; suf = 8'h1F; end
    endcase
    nblk = len / r + 1;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < r; j++) begin
        idx = b * r + j;
        if (idx < len) blk[j*8 +: 8] = pat(idx);
      end
      lst = (b == nblk - 1);
      if (lst) begin
        blk[(len % r)*8 +: 8] = blk[(len % r)*8 +: 8] | suf;
        blk[(r - 1)*8 +: 8]   = blk[(r - 1)*8 +: 8] | 8'h80;
      end
      exp_q.push_back(blk);
      exp_meta_q.push_back({lst, 8'(r)});
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [BW-1:0] ed;
    logic [8:0]    em;
    if (rst_n && blk_valid_o && blk_ready_i) begin
      blk_seen++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_block: got block with rate %0d, expected none", blk_rate_o);
      end else begin
        ed = exp_q.pop_front();
        em = exp_meta_q.pop_front();
        check_block("blk_data", blk_data_o, ed);
        check_val("blk_last", 32'(blk_last_o), 32'(em[8]));
        check_val("blk_rate", 32'(blk_rate_o), 32'(em[7:0]));
      end
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic do_start(input logic [1:0] mode);
    mode_i  = mode;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [DWIDTH-1:0] d, input logic [NB-1:0] k, input logic l);
    int cnt;
    in_data_i  = d;
    in_keep_i  = k;
    in_last_i  = l;
    in_valid_i = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!in_ready_o && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept: got no in_ready_o in 200 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int to, input bit last_final);
    int                off;
    int                cnt;
    logic [DWIDTH-1:0] d;
    logic [NB-1:0]     k;
    off = from;
    while (off < to) begin
      cnt = (to - off > NB) ? NB : to - off;
      d = '0;
      k = '0;
      for (int j = 0; j < cnt; j++) begin
        d[j*8 +: 8] = pat(off + j);
        k[j]        = 1'b1;
      end
      send_beat(d, k, last_final && (off + cnt == to));
      off += cnt;
    end
  endtask

  task automatic send_msg(input int len);
    if (len == 0) send_beat('0, '0, 1'b1);
    else          send_bytes(0, len, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (busy_o && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check_val({name, "_idle"}, 32'(busy_o), 32'd0);
    check_val({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_msg(input string name, input int mode, input int len, input logic [7:0] s);
    seed = s;
    push_msg(mode, len);
    do_start(2'(mode));
    check_val({name, "_busy"}, 32'(busy_o), 32'd1);
    send_msg(len);
    wait_idle(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cnt;
    int seen0;
    rst_n = 1'b0; mode_i = '0; start_i = 1'b0; in_data_i = '0; in_keep_i = '0;
    in_valid_i = 1'b0; in_last_i = 1'b0; blk_ready_i = 1'b1; seed = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(blk_valid_o), 32'd0);
    check_val("rst_ready", 32'(in_ready_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_val("rst_last", 32'(blk_last_o), 32'd0);
    check_val("rst_rate", 32'(blk_rate_o), 32'd0);
    check_block("rst_data", blk_data_o, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_msg("sha256_empty", 0, 0,   8'h11);
    run_msg("sha256_135",   0, 135, 8'h22);
    run_msg("shake128_168", 2, 168, 8'h33);
    run_msg("sha256_160",   0, 160, 8'h44);
    run_msg("sha512_71",    1, 71,  8'h55);
    run_msg("shake128_167", 2, 167, 8'h66);

    // start_i pulse mid-message with a different mode must be ignored
    seed = 8'h77;
    push_msg(3, 300);
    do_start(2'd3);
    send_bytes(0, 64, 1'b0);
    mode_i  = 2'd1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check_val("restart_busy", 32'(busy_o), 32'd1);
    check_val("restart_state", 32'(dbg_state), 32'd1);
    send_bytes(64, 300, 1'b1);
    wait_idle("shake256_300");

    // backpressure: SHA3_512, 96 bytes then an empty last beat
    seed = 8'h88;
    push_msg(1, 96);
    seen0 = blk_seen;
    do_start(2'd1);
    blk_ready_i = 1'b0;
    send_bytes(0, 96, 1'b0);
    cnt = 0;
    @(negedge clk);
    while (!blk_valid_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      check_val("stall_valid", 32'(blk_valid_o), 32'd1);
      check_val("stall_in_ready", 32'(in_ready_o), 32'd0);
      check_block("stall_data", blk_data_o, exp_q[0]);
      @(negedge clk);
    end
    @(posedge clk); #1;
    blk_ready_i = 1'b1;
    send_beat('0, '0, 1'b1);
    wait_idle("sha512_stall");
    check_val("stall_handshakes", 32'(blk_seen - seen0), 32'd2);

    // reset in the middle of FILL
    seed = 8'h99;
    do_start(2'd0);
    send_bytes(0, 64, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy_o), 32'd0);
    check_val("midrst_valid", 32'(blk_valid_o), 32'd0);
    check_val("midrst_ready", 32'(in_ready_o), 32'd0);
    check_val("midrst_rate", 32'(blk_rate_o), 32'd0);
    check_block("midrst_data", blk_data_o, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_data_i  = '1;
    in_keep_i  = '1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("nostart_ready", 32'(in_ready_o), 32'd0);
      check_val("nostart_busy", 32'(busy_o), 32'd0);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    run_msg("post_reset_empty", 0, 0, 8'hAB);

    check_val("blocks_total", 32'(blk_seen), 32'd14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
